sprite_batch_draw: RTL

//  Parametrised object-draw sequencer for the neuroevolution display path. On start, it walks

---
 rtl/sprite_batch_draw.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_batch_draw.sv
// sprite_batch_draw: walks objects 0..count-1, fetches each object's X and Y
// through the shared datapath, then draws a SPRITE_W x SPRITE_H block at that
// position. Pixels that fall off the right or bottom screen edge are skipped.
// Erase mode draws the block in BG_COLOUR.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef COLOUR_WIDTH
`define COLOUR_WIDTH 3
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 8
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef X_COORD_WIDTH
`define X_COORD_WIDTH 8
`endif
`ifndef Y_COORD_WIDTH
`define Y_COORD_WIDTH 7
`endif
`ifndef OPCODE_MEMREAD
`define OPCODE_MEMREAD 3'd1
`endif
`ifndef OPCODE_DRAW
`define OPCODE_DRAW 3'd2
`endif

module sprite_batch_draw #(
  parameter int unsigned NUM_OBJECTS = 8,
  parameter int unsigned SPRITE_W    = 2,
  parameter int unsigned SPRITE_H    = 2,
  parameter int unsigned X_BASE_ADDR = 0,
  parameter int unsigned Y_BASE_ADDR = 1,
  parameter int unsigned ADDR_STRIDE = 2,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter logic [`COLOUR_WIDTH-1:0] BG_COLOUR = 3'b000
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           start,
  output logic                           finished,
  input  logic [`MEM_ADDR_WIDTH-1:0]     obj_count,
  input  logic [`COLOUR_WIDTH-1:0]       colour_in,
  input  logic                           erase,
  output logic [`MEM_ADDR_WIDTH-1:0]     cur_obj,
  input  logic                           finished_dp,
  input  logic [`RESULT_WIDTH-1:0]       result_dp,
  output logic                           start_dp,
  output logic [`INSTRUCTION_WIDTH-1:0]  instruction_dp
);

  localparam int AW     = `MEM_ADDR_WIDTH;
  localparam int CW     = `COLOUR_WIDTH;
  localparam int IW     = `INSTRUCTION_WIDTH;
  localparam int XW     = `X_COORD_WIDTH;
  localparam int YW     = `Y_COORD_WIDTH;
  localparam int OW     = 3;
  localparam int DXW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int DYW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int DRAW_W = 1 + CW + YW + XW + OW;
  localparam int READ_W = AW + OW;

  localparam logic [DXW-1:0] DX_LAST   = DXW'(SPRITE_W - 1);
  localparam logic [DYW-1:0] DY_LAST   = DYW'(SPRITE_H - 1);
  localparam logic [AW-1:0]  MAX_COUNT = AW'(NUM_OBJECTS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_NEXT_OBJ = 3'd1,
    S_ISSUE    = 3'd2,
    S_HOLD     = 3'd3,
    S_WAIT     = 3'd4,
    S_SKIP     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_LDX  = 2'd0,
    OP_LDY  = 2'd1,
    OP_DRAW = 2'd2
  } op_t;

  state_t          state_r, state_s;
  op_t             op_r, op_s;
  logic [AW-1:0]   count_r, count_s;
  logic [AW-1:0]   cur_obj_r, cur_obj_s;
  logic [CW-1:0]   colour_r, colour_s;
  logic            erase_r, erase_s;
  logic [XW-1:0]   x0_r, x0_s;
  logic [YW-1:0]   y0_r, y0_s;
  logic [DXW-1:0]  dx_r, dx_s;
  logic [DYW-1:0]  dy_r, dy_s;
  logic            finished_r, finished_s;
  logic            start_dp_r;
  logic [IW-1:0]   instr_r, instr_s;

  logic            step_wrap_s;
  logic            step_last_s;
  logic [DXW-1:0]  step_dx_s;
  logic [DYW-1:0]  step_dy_s;
  logic [YW-1:0]   first_y_s;
  logic [CW-1:0]   draw_colour_s;
  logic            vis_first_s;
  logic            vis_step_s;

  // Memory-read instruction for one coordinate of object obj.
  function automatic logic [IW-1:0] read_instr(input logic [AW-1:0] base,
                                               input logic [AW-1:0] obj);
    logic [AW-1:0] addr;
    addr = base + obj * AW'(ADDR_STRIDE);
    return {{(IW-READ_W){1'b0}}, addr, `OPCODE_MEMREAD};
  endfunction

  // Pixel is on screen; the sums are one bit wider so wrap-around cannot hide a clip.
  function automatic logic pixel_visible(input logic [XW-1:0] x0, input logic [YW-1:0] y0,
                                         input logic [DXW-1:0] dx, input logic [DYW-1:0] dy);
    logic [XW:0] px;
    logic [YW:0] py;
    px = {1'b0, x0} + (XW+1)'(dx);
    py = {1'b0, y0} + (YW+1)'(dy);
    return (px < (XW+1)'(SCREEN_W)) && (py < (YW+1)'(SCREEN_H));
  endfunction

  // Draw instruction for a pixel already known to be on screen.
  function automatic logic [IW-1:0] draw_instr(input logic [CW-1:0] colour,
                                               input logic [XW-1:0] x0, input logic [YW-1:0] y0,
                                               input logic [DXW-1:0] dx, input logic [DYW-1:0] dy);
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    px = x0 + XW'(dx);
    py = y0 + YW'(dy);
    return {{(IW-DRAW_W){1'b0}}, 1'b1, colour, py, px, `OPCODE_DRAW};
  endfunction

  // Raster stepping: dx runs fastest, wrapping into dy.
  assign step_wrap_s   = (dx_r == DX_LAST);
  assign step_last_s   = step_wrap_s && (dy_r == DY_LAST);
  assign step_dx_s     = step_wrap_s ? {DXW{1'b0}} : dx_r + DXW'(1);
  assign step_dy_s     = step_wrap_s ? dy_r + DYW'(1) : dy_r;
  assign first_y_s     = result_dp[YW-1:0];
  assign draw_colour_s = erase_r ? BG_COLOUR : colour_r;
  assign vis_first_s   = pixel_visible(x0_r, first_y_s, {DXW{1'b0}}, {DYW{1'b0}});
  assign vis_step_s    = pixel_visible(x0_r, y0_r, step_dx_s, step_dy_s);

  // Next-state and next-register logic for the object/pixel sequencer.
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    count_s    = count_r;
    cur_obj_s  = cur_obj_r;
    colour_s   = colour_r;
    erase_s    = erase_r;
    x0_s       = x0_r;
    y0_s       = y0_r;
    dx_s       = dx_r;
    dy_s       = dy_r;
    finished_s = finished_r;
    instr_s    = instr_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          count_s    = (obj_count > MAX_COUNT) ? MAX_COUNT : obj_count;
          colour_s   = colour_in;
          erase_s    = erase;
          cur_obj_s  = {AW{1'b0}};
          finished_s = 1'b0;
          state_s    = S_NEXT_OBJ;
        end else begin
          finished_s = 1'b1;
        end
      end
      S_NEXT_OBJ: begin
        if (cur_obj_r == count_r) begin
          state_s = S_IDLE;
        end else begin
          op_s    = OP_LDX;
          instr_s = read_instr(AW'(X_BASE_ADDR), cur_obj_r);
          state_s = S_ISSUE;
        end
      end
      S_ISSUE: state_s = S_HOLD;
      S_HOLD:  state_s = S_WAIT;
      S_WAIT: begin
        if (finished_dp) begin
          case (op_r)
            OP_LDX: begin
              x0_s    = result_dp[XW-1:0];
              op_s    = OP_LDY;
              instr_s = read_instr(AW'(Y_BASE_ADDR), cur_obj_r);
              state_s = S_ISSUE;
            end
            OP_LDY: begin
              y0_s    = first_y_s;
              dx_s    = {DXW{1'b0}};
              dy_s    = {DYW{1'b0}};
              op_s    = OP_DRAW;
              instr_s = vis_first_s ? draw_instr(draw_colour_s, x0_r, first_y_s, {DXW{1'b0}}, {DYW{1'b0}})
                                    : instr_r;
              state_s = vis_first_s ? S_ISSUE : S_SKIP;
            end
            OP_DRAW: begin
              if (step_last_s) begin
                dx_s      = {DXW{1'b0}};
                dy_s      = {DYW{1'b0}};
                cur_obj_s = cur_obj_r + AW'(1);
                state_s   = S_NEXT_OBJ;
              end else begin
                dx_s    = step_dx_s;
                dy_s    = step_dy_s;
                instr_s = vis_step_s ? draw_instr(draw_colour_s, x0_r, y0_r, step_dx_s, step_dy_s)
                                     : instr_r;
                state_s = vis_step_s ? S_ISSUE : S_SKIP;
              end
            end
            default: state_s = S_IDLE;
          endcase
        end else begin
          state_s = S_WAIT;
        end
      end
      S_SKIP: begin
        if (step_last_s) begin
          dx_s      = {DXW{1'b0}};
          dy_s      = {DYW{1'b0}};
          cur_obj_s = cur_obj_r + AW'(1);
          state_s   = S_NEXT_OBJ;
        end else begin
          dx_s    = step_dx_s;
          dy_s    = step_dy_s;
          instr_s = vis_step_s ? draw_instr(draw_colour_s, x0_r, y0_r, step_dx_s, step_dy_s)
                               : instr_r;
          state_s = vis_step_s ? S_ISSUE : S_SKIP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State and datapath registers; start_dp is registered off the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= S_IDLE;
      op_r       <= OP_LDX;
      count_r    <= {AW{1'b0}};
      cur_obj_r  <= {AW{1'b0}};
      colour_r   <= {CW{1'b0}};
      erase_r    <= 1'b0;
      x0_r       <= {XW{1'b0}};
      y0_r       <= {YW{1'b0}};
      dx_r       <= {DXW{1'b0}};
      dy_r       <= {DYW{1'b0}};
      finished_r <= 1'b1;
      start_dp_r <= 1'b0;
      instr_r    <= {IW{1'b0}};
    end else begin
      state_r    <= state_s;
      op_r       <= op_s;
      count_r    <= count_s;
      cur_obj_r  <= cur_obj_s;
      colour_r   <= colour_s;
      erase_r    <= erase_s;
      x0_r       <= x0_s;
      y0_r       <= y0_s;
      dx_r       <= dx_s;
      dy_r       <= dy_s;
      finished_r <= finished_s;
      start_dp_r <= (state_s == S_ISSUE) || (state_s == S_HOLD);
      instr_r    <= instr_s;
    end
  end

  assign finished       = finished_r;
  assign cur_obj        = cur_obj_r;
  assign start_dp       = start_dp_r;
  assign instruction_dp = instr_r;

endmodule
